// File: rtl/serial_out_pkg.sv
// serial_out_pkg: shared state encoding and sizing helpers for the serial output transmitter.
// SERIAL_OUT_PARITY_EN adds one parity bit to the frame width.
package serial_out_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
`ifdef SERIAL_OUT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  function automatic int frame_w(input int aw, input int dw);
    return aw + dw + PAR_W;
  endfunction
  function automatic int cnt_w(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_out_sync_fifo.sv
// serial_out_sync_fifo: DEPTH-entry synchronous FIFO with registered full/empty flags.
module serial_out_sync_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_n;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign cnt_n = cnt + CW'(do_push) - CW'(do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop) rp <= rp + PW'(1);
      cnt <= cnt_n;
      full <= cnt_n == CW'(DEPTH);
      empty <= cnt_n == '0;
    end
  end
  always_ff @(posedge clk_in)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/serial_out_fifo_tx.sv
// serial_out_fifo_tx: queues {A,D} words and shifts each out MSB-first with a strobe on OutC.
// Define SERIAL_OUT_PARITY_EN to append an even-parity bit after the data LSB.
module serial_out_fifo_tx #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 7,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] A,
  input  logic              Go,
  output logic              Ready,
  output logic              Ovf,
  output logic              Busy,
  output logic              Done,
  output logic              OutD,
  output logic              OutC
);
  import serial_out_pkg::*;
  localparam int WW = ADDR_W + DATA_W;
  localparam int FW = frame_w(ADDR_W, DATA_W);
  localparam int DW = cnt_w(CLK_DIV);
  localparam int BW = cnt_w(FW);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  logic [WW-1:0] word;
  logic [FW-1:0] frame, sh, sh_n;
  logic [1:0] state, state_n;
  logic [DW-1:0] div, div_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic full, empty, pop, div_last;
  serial_out_sync_fifo #(.W(WW), .DEPTH(DEPTH)) u_fifo (
    .clk_in(clk_in), .reset_n(reset_n), .push(Go), .pop(pop),
    .wdata({A, D}), .rdata(word), .full(full), .empty(empty)
  );
  assign Ready = ~full;
  assign div_last = div == DIV_LAST;
`ifdef SERIAL_OUT_PARITY_EN
  assign frame = {word, ^word};
`else
  assign frame = word;
`endif
  always_comb begin
    state_n = state;
    div_n = div_last ? '0 : div + DW'(1);
    bit_n = bit_cnt;
    sh_n = sh;
    pop = 1'b0;
    case (state)
      S_IDLE: begin
        div_n = '0;
        if (!empty) begin
          pop = 1'b1;
          sh_n = frame;
          bit_n = '0;
          state_n = S_LOW;
        end
      end
      S_LOW: state_n = div_last ? S_HIGH : S_LOW;
      S_HIGH: begin
        if (div_last && bit_cnt == BIT_LAST) state_n = S_GAP;
        else if (div_last) begin
          state_n = S_LOW;
          bit_n = bit_cnt + BW'(1);
          sh_n = sh << 1;
        end
      end
      default: state_n = div_last ? S_IDLE : S_GAP;
    endcase
  end
  // Outputs are registered from next-state values so they align with the state they describe.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      div <= '0;
      bit_cnt <= '0;
      sh <= '0;
      OutD <= 1'b0;
      OutC <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      Ovf <= 1'b0;
    end else begin
      state <= state_n;
      div <= div_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      OutC <= state_n == S_HIGH;
      OutD <= (state_n == S_LOW || state_n == S_HIGH) & sh_n[FW-1];
      Busy <= state_n != S_IDLE;
      Done <= state_n == S_GAP && div_n == DIV_LAST;
      Ovf <= Ovf | (Go & full);
    end
  end
endmodule

// File: tb/tb_serial_out_fifo_tx.sv
// tb_serial_out_fifo_tx: directed and randomized checks of serial_out_fifo_tx against a frame-level model.
module tb_serial_out_fifo_tx;
  localparam int DATA_W = 8, ADDR_W = 7, DEPTH = 4, CLK_DIV = 2;
`ifdef SERIAL_OUT_PARITY_EN
  localparam int FW = ADDR_W + DATA_W + 1;
`else
  localparam int FW = ADDR_W + DATA_W;
`endif
  localparam int BUSY_CYC = FW * 2 * CLK_DIV + CLK_DIV;
  logic clk_in = 1'b0;
  logic reset_n;
  logic [DATA_W-1:0] D;
  logic [ADDR_W-1:0] A;
  logic Go, Ready, Ovf, Busy, Done, OutD, OutC;
  int n_cmp = 0, n_fail = 0;
  int rises = 0, dones = 0, busy_cyc = 0, nb = 0;
  logic prev_c = 1'b0;
  logic [31:0] acc = '0;
  logic [FW-1:0] rx_q[$];
  int rx_n[$];
  logic [ADDR_W-1:0] wa[8];
  logic [DATA_W-1:0] wd[8];
  int r0, d0, b0, n, n_acc;
  logic [FW-1:0] ef;

  serial_out_fifo_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .D(D), .A(A), .Go(Go), .Ready(Ready),
    .Ovf(Ovf), .Busy(Busy), .Done(Done), .OutD(OutD), .OutC(OutC)
  );

  always #5 clk_in = ~clk_in;

  // Receiver: samples OutD on each OutC rising edge, closes a frame on Done.
  always @(negedge clk_in) begin
    if (!reset_n) begin
      acc = '0;
      nb = 0;
      prev_c = 1'b0;
    end else begin
      if (OutC && !prev_c) begin
        acc = {acc[30:0], OutD};
        nb++;
        rises++;
      end
      prev_c = OutC;
      if (Busy) busy_cyc++;
      if (Done) begin
        dones++;
        rx_q.push_back(acc[FW-1:0]);
        rx_n.push_back(nb);
        acc = '0;
        nb = 0;
      end
    end
  end

  function automatic logic [FW-1:0] frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
`ifdef SERIAL_OUT_PARITY_EN
    return {a, d, 1'($countones({a, d}) % 2)};
`else
    return {a, d};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int idle = 0, t = 0;
    while (idle < 3 && t < 20000) begin
      @(negedge clk_in);
      idle = Busy ? 0 : idle + 1;
      t++;
    end
    chk("idle_timeout", 64'(t < 20000), 1);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_n = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b1;
    rx_q.delete();
    rx_n.delete();
  endtask

  task automatic burst(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk_in);
      Go = 1'b1;
      A = wa[i];
      D = wd[i];
    end
    @(negedge clk_in);
    Go = 1'b0;
  endtask

  task automatic check_rx(input string tag, input int cnt);
    chk($sformatf("%s_frames", tag), 64'(rx_q.size()), 64'(cnt));
    for (int i = 0; i < cnt && rx_q.size() > 0; i++) begin
      chk($sformatf("%s_frame%0d", tag, i), 64'(rx_q.pop_front()), 64'(frame(wa[i], wd[i])));
      chk($sformatf("%s_bits%0d", tag, i), 64'(rx_n.pop_front()), 64'(FW));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    Go = 1'b0;
    A = '0;
    D = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk($sformatf("rst_outputs%0d", i), {OutD, OutC, Busy, Done, Ovf, Ready}, 6'b000001);
      Go = ~Go;
      A = 7'h55;
      D = 8'hA3;
    end
    Go = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b1;
    r0 = rises;
    repeat (20) @(negedge clk_in);
    chk("idle_no_strobe", 64'(rises - r0), 0);
    chk("idle_busy", Busy, 0);

    wa[0] = 7'h55;
    wd[0] = 8'hA3;
    ef = frame(wa[0], wd[0]);
    r0 = rises;
    d0 = dones;
    b0 = busy_cyc;
    @(negedge clk_in);
    Go = 1'b1;
    A = wa[0];
    D = wd[0];
    @(negedge clk_in);
    Go = 1'b0;
    chk("lat_busy_edge1", Busy, 0);
    chk("lat_outd_edge1", OutD, 0);
    @(negedge clk_in);
    chk("lat_busy_edge2", Busy, 1);
    chk("lat_outd_edge2", OutD, ef[FW-1]);
    wait_idle();
    chk("single_busy_cycles", 64'(busy_cyc - b0), 64'(BUSY_CYC));
    chk("single_rises", 64'(rises - r0), 64'(FW));
    chk("single_done", 64'(dones - d0), 1);
    check_rx("single", 1);

    do_reset();
    d0 = dones;
    for (int i = 0; i < 6; i++) begin
      wa[i] = ADDR_W'(i);
      wd[i] = DATA_W'(i);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (i == 4) chk("burst_ready_before_full", Ready, 1);
      if (i == 5) chk("burst_ready_full", Ready, 0);
      if (i == 5) chk("burst_ovf_before_drop", Ovf, 0);
      Go = 1'b1;
      A = wa[i];
      D = wd[i];
    end
    @(negedge clk_in);
    Go = 1'b0;
    chk("burst_ovf", Ovf, 1);
    wait_idle();
    chk("burst_dones", 64'(dones - d0), 5);
    check_rx("burst", 5);
    chk("burst_ovf_sticky", Ovf, 1);

    do_reset();
    chk("ovf_cleared", Ovf, 0);
    wa[0] = ADDR_W'($urandom);
    wd[0] = DATA_W'($urandom);
    wa[1] = ADDR_W'($urandom);
    wd[1] = DATA_W'($urandom);
    r0 = rises;
    burst(2);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk_in);
      if (rises - r0 >= 6 && !OutC) break;
    end
    chk("abort_reached_bit7", 64'(rises - r0), 6);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_outputs", {OutD, OutC, Busy, Done, Ready}, 5'b00001);
    @(negedge clk_in);
    reset_n = 1'b1;
    d0 = dones;
    r0 = rises;
    repeat (300) @(negedge clk_in);
    chk("abort_no_done", 64'(dones - d0), 0);
    chk("abort_no_strobe", 64'(rises - r0), 0);
    chk("abort_no_frames", 64'(rx_q.size()), 0);

`ifdef SERIAL_OUT_PARITY_EN
    do_reset();
    wa[0] = 7'h01;
    wd[0] = 8'h01;
    wa[1] = 7'h01;
    wd[1] = 8'h00;
    burst(2);
    wait_idle();
    chk("par_frames", 64'(rx_q.size()), 2);
    if (rx_q.size() == 2) begin
      chk("par_last_even", 64'(rx_q[0][0]), 0);
      chk("par_last_odd", 64'(rx_q[1][0]), 1);
    end
    check_rx("par", 2);
`endif

    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = $urandom_range(1, DEPTH + 3);
      for (int i = 0; i < 8; i++) begin
        wa[i] = ADDR_W'($urandom);
        wd[i] = DATA_W'($urandom);
      end
      burst(n);
      n_acc = n < DEPTH + 1 ? n : DEPTH + 1;
      chk($sformatf("rnd%0d_ovf", it), Ovf, 64'(n > DEPTH + 1));
      wait_idle();
      check_rx($sformatf("rnd%0d", it), n_acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
